// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared sizing defaults and decoder encodings for the hazard scoreboard
// Sizing defaults, exe_cmd encodings and the src1-usage decode shared with the ID decoder.
package hazard_scoreboard_pkg;

  localparam int REG_W_DEF    = 4;
  localparam int DEPTH_DEF    = 2;
  localparam int LOAD_RDY_DEF = 1;
  localparam int CNT_W_DEF    = 16;

  localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [3:0] EXE_CMD_MVN = 4'b1001;

  // MOV and MVN take only the shifter operand, so their first source is never read.
  function automatic logic src1_read(input logic [3:0] exe_cmd);
    return (exe_cmd != EXE_CMD_MOV) && (exe_cmd != EXE_CMD_MVN);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard/statistics response bundle
// The master is the ID stage; the slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic             id_src1_used;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_used;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_r_en;
  logic             fwd_en;
  logic             mem_ready;
  logic             flush;
  logic             hazard_detected;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] load_use_cnt;

  modport master (
    output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_wb_en, id_dest, id_mem_r_en, fwd_en, mem_ready, flush,
    input  hazard_detected, freeze, stall_cnt, load_use_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
           id_wb_en, id_dest, id_mem_r_en, fwd_en, mem_ready, flush,
    output hazard_detected, freeze, stall_cnt, load_use_cnt
  );
endinterface

// File: rtl/hz_entry_match.sv
// rtl/hz_entry_match.sv - compares one in-flight entry against the two ID source registers
// load_match flags a match whose producer is a load.
module hz_entry_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ent_v_i,
  input  logic [REG_W-1:0] ent_dest_i,
  input  logic             ent_ld_i,
  input  logic [REG_W-1:0] src1_i,
  input  logic             src1_used_i,
  input  logic [REG_W-1:0] src2_i,
  input  logic             src2_used_i,
  output logic             match_o,
  output logic             load_match_o
);

  logic hit1;
  logic hit2;

  assign hit1         = src1_used_i & (src1_i == ent_dest_i);
  assign hit2         = src2_used_i & (src2_i == ent_dest_i);
  assign match_o      = ent_v_i & (hit1 | hit2);
  assign load_match_o = match_o & ent_ld_i;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker driving IF/ID hold and ID/EXE bubble
// Entry 0 is EXE; entries shift one stage per unfrozen cycle and retire after DEPTH advances.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LOAD_RDY = LOAD_RDY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_scoreboard_if.slave  bus
);

  // Entries younger than LOAD_RDY hold load data that cannot yet be forwarded.
  localparam logic [DEPTH-1:0] EARLY_MASK = {DEPTH{1'b1}} >> (DEPTH - LOAD_RDY);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0]            ld_q, ld_d;
  logic [DEPTH-1:0][REG_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]            load_use_cnt_q, load_use_cnt_d;

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] load_match;
  logic             raw_hazard;
  logic             load_only;
  logic             freeze;
  logic             count_stall;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    hz_entry_match #(
      .REG_W (REG_W)
    ) u_match (
      .ent_v_i      (v_q[i]),
      .ent_dest_i   (dest_q[i]),
      .ent_ld_i     (ld_q[i]),
      .src1_i       (bus.id_src1),
      .src1_used_i  (bus.id_src1_used),
      .src2_i       (bus.id_src2),
      .src2_used_i  (bus.id_src2_used),
      .match_o      (match[i]),
      .load_match_o (load_match[i])
    );
  end

  always_comb begin
    raw_hazard = 1'b0;
    load_only  = 1'b1;
    if (bus.fwd_en) begin
      raw_hazard = bus.id_valid & (|(load_match & EARLY_MASK));
    end else begin
      raw_hazard = bus.id_valid & (|match);
      load_only  = ~(|(match & ~load_match));
    end
  end

  assign freeze      = ~bus.mem_ready;
  assign count_stall = bus.mem_ready & ~bus.flush & raw_hazard;

  assign bus.freeze          = freeze;
  assign bus.hazard_detected = freeze | (raw_hazard & ~bus.flush);
  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.load_use_cnt    = load_use_cnt_q;

  always_comb begin
    v_d            = v_q;
    ld_d           = ld_q;
    dest_d         = dest_q;
    stall_cnt_d    = stall_cnt_q;
    load_use_cnt_d = load_use_cnt_q;
    if (bus.mem_ready) begin
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]    = v_q[i-1];
        ld_d[i]   = ld_q[i-1];
        dest_d[i] = dest_q[i-1];
      end
      if (bus.id_valid & bus.id_wb_en & ~raw_hazard & ~bus.flush) begin
        v_d[0]    = 1'b1;
        ld_d[0]   = bus.id_mem_r_en;
        dest_d[0] = bus.id_dest;
      end else begin
        v_d[0]    = 1'b0;
        ld_d[0]   = 1'b0;
        dest_d[0] = '0;
      end
      if (count_stall && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (count_stall && load_only && load_use_cnt_q != {CNT_W{1'b1}}) begin
        load_use_cnt_d = load_use_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q            <= '0;
      ld_q           <= '0;
      dest_q         <= '0;
      stall_cnt_q    <= '0;
      load_use_cnt_q <= '0;
    end else begin
      v_q            <= v_d;
      ld_q           <= ld_d;
      dest_q         <= dest_d;
      stall_cnt_q    <= stall_cnt_d;
      load_use_cnt_q <= load_use_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench for two scoreboard configurations
// Instance a: DEPTH=2, LOAD_RDY=1, CNT_W=16. Instance b: DEPTH=3, LOAD_RDY=2, CNT_W=3 (reaches saturation quickly).
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  typedef struct {
    bit       live;
    bit [3:0] dest;
    bit       ld;
    int       age;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  rec_t pool [2][8];
  int   m_stall [2];
  int   m_lu [2];

  hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) if_a ();
  hazard_scoreboard_if #(.REG_W(4), .CNT_W(3))  if_b ();

  hazard_scoreboard #(.REG_W(4), .DEPTH(2), .LOAD_RDY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .LOAD_RDY(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  always #5 clk = ~clk;

  function automatic int dep_of(input int c);  return (c == 0) ? 2 : 3; endfunction
  function automatic int lrdy_of(input int c); return (c == 0) ? 1 : 2; endfunction
  function automatic int cmax_of(input int c); return (c == 0) ? 65535 : 7; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit rec_hits(input int c, input int k, input bit [3:0] s1, input bit u1,
                                  input bit [3:0] s2, input bit u2);
    return pool[c][k].live && ((u1 && s1 == pool[c][k].dest) || (u2 && s2 == pool[c][k].dest));
  endfunction

  // A write stalls a reader unless it is forwardable: ALU results always are, loads once old enough.
  function automatic bit model_hazard(input int c, input bit v, input bit [3:0] s1, input bit u1,
                                      input bit [3:0] s2, input bit u2, input bit fwd);
    bit h = 1'b0;
    for (int k = 0; k < 8; k++)
      if (rec_hits(c, k, s1, u1, s2, u2) && (!fwd || (pool[c][k].ld && pool[c][k].age < lrdy_of(c))))
        h = 1'b1;
    return v && h;
  endfunction

  function automatic bit model_alu_hit(input int c, input bit [3:0] s1, input bit u1,
                                       input bit [3:0] s2, input bit u2);
    bit a = 1'b0;
    for (int k = 0; k < 8; k++)
      if (rec_hits(c, k, s1, u1, s2, u2) && !pool[c][k].ld) a = 1'b1;
    return a;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) pool[c][k] = '{live: 1'b0, dest: 4'd0, ld: 1'b0, age: 0};
      m_stall[c] = 0;
      m_lu[c]    = 0;
    end
  endtask

  task automatic drive(input bit v, input bit [3:0] s1, input bit u1, input bit [3:0] s2, input bit u2,
                       input bit wb, input bit [3:0] dst, input bit ld, input bit fwd, input bit mr,
                       input bit fl);
    if_a.id_valid = v;  if_a.id_src1 = s1; if_a.id_src1_used = u1; if_a.id_src2 = s2;
    if_a.id_src2_used = u2; if_a.id_wb_en = wb; if_a.id_dest = dst; if_a.id_mem_r_en = ld;
    if_a.fwd_en = fwd; if_a.mem_ready = mr; if_a.flush = fl;
    if_b.id_valid = v;  if_b.id_src1 = s1; if_b.id_src1_used = u1; if_b.id_src2 = s2;
    if_b.id_src2_used = u2; if_b.id_wb_en = wb; if_b.id_dest = dst; if_b.id_mem_r_en = ld;
    if_b.fwd_en = fwd; if_b.mem_ready = mr; if_b.flush = fl;
  endtask

  task automatic step(input bit v, input bit [3:0] s1, input bit u1, input bit [3:0] s2, input bit u2,
                      input bit wb, input bit [3:0] dst, input bit ld, input bit fwd, input bit mr,
                      input bit fl);
    bit h;
    bit alu;
    bit slot_found;
    @(negedge clk);
    chk("stall_cnt_a", 32'(if_a.stall_cnt), m_stall[0]);
    chk("load_use_cnt_a", 32'(if_a.load_use_cnt), m_lu[0]);
    chk("stall_cnt_b", 32'(if_b.stall_cnt), m_stall[1]);
    chk("load_use_cnt_b", 32'(if_b.load_use_cnt), m_lu[1]);
    drive(v, s1, u1, s2, u2, wb, dst, ld, fwd, mr, fl);
    #1;
    for (int c = 0; c < 2; c++) begin
      h   = model_hazard(c, v, s1, u1, s2, u2, fwd);
      alu = model_alu_hit(c, s1, u1, s2, u2);
      chk(c == 0 ? "hazard_a" : "hazard_b",
          32'(c == 0 ? if_a.hazard_detected : if_b.hazard_detected), 32'(!mr || (h && !fl)));
      chk(c == 0 ? "freeze_a" : "freeze_b", 32'(c == 0 ? if_a.freeze : if_b.freeze), 32'(!mr));
      if (mr) begin
        if (h && !fl) begin
          if (m_stall[c] < cmax_of(c)) m_stall[c]++;
          if ((fwd || !alu) && m_lu[c] < cmax_of(c)) m_lu[c]++;
        end
        for (int k = 0; k < 8; k++) begin
          if (pool[c][k].live) begin
            pool[c][k].age++;
            if (pool[c][k].age >= dep_of(c)) pool[c][k].live = 1'b0;
          end
        end
        if (v && wb && !h && !fl) begin
          slot_found = 1'b0;
          for (int k = 0; k < 8; k++) begin
            if (!pool[c][k].live && !slot_found) begin
              pool[c][k] = '{live: 1'b1, dest: dst, ld: ld, age: 0};
              slot_found = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit fwd);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, fwd, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    if_a.mem_ready = 1'b1;
    if_b.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_stall_a", 32'(if_a.stall_cnt), m_stall[0]);
    chk("rst_lu_a", 32'(if_a.load_use_cnt), m_lu[0]);
    chk("rst_stall_b", 32'(if_b.stall_cnt), m_stall[1]);
    chk("rst_hazard_a", 32'(if_a.hazard_detected), 32'd0);
    chk("rst_hazard_b", 32'(if_b.hazard_detected), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit [3:0] pick_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_a", 32'(if_a.stall_cnt), 32'd0);
    chk("reset_lu_b", 32'(if_b.load_use_cnt), 32'd0);
    chk("reset_hazard_a", 32'(if_a.hazard_detected), 32'd0);
    rst_n = 1'b1;

    // ALU producer, no forwarding: reader holds until the write retires.
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0);
    repeat (3) step(1, 3, 1, 7, 0, 1, 8, 0, 0, 1, 0);
    idle(4, 0);
    // Forwarding: load producer stalls, ALU producer does not.
    step(1, 0, 0, 0, 0, 1, 5, 1, 1, 1, 0);
    repeat (3) step(1, 9, 1, 5, 1, 1, 6, 0, 1, 1, 0);
    idle(4, 1);
    step(1, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0);
    step(1, 9, 1, 5, 1, 1, 6, 0, 1, 1, 0);
    idle(4, 1);
    // Load user two and three slots behind.
    step(1, 0, 0, 0, 0, 1, 2, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (2) step(1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 2, 1, 1, 1, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(4, 1);
    // Memory busy with a load in EXE, including a flush held through the freeze.
    step(1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0);
    repeat (3) step(1, 1, 1, 0, 0, 1, 4, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 1, 4, 0, 1, 0, 1);
    repeat (3) step(1, 1, 1, 0, 0, 1, 4, 0, 1, 1, 0);
    idle(4, 1);
    // Flush against a live hazard.
    step(1, 0, 0, 0, 0, 1, 6, 0, 0, 1, 0);
    step(1, 6, 1, 0, 0, 1, 7, 0, 0, 1, 1);
    step(1, 7, 1, 6, 1, 0, 0, 0, 0, 1, 0);
    idle(4, 0);
    // MOV does not read src1; r15 is tracked like any register.
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0);
    step(1, 4, src1_read(EXE_CMD_MOV), 0, 0, 1, 15, 0, 0, 1, 0);
    step(1, 15, src1_read(EXE_CMD_MVN), 15, 1, 0, 0, 0, 0, 1, 0);
    repeat (3) step(1, 15, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    // Reset while a stall is in progress.
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, 1, 0);
    step(1, 3, 1, 3, 1, 1, 2, 0, 0, 1, 0);
    do_reset();
    step(1, 3, 1, 3, 1, 1, 2, 0, 0, 1, 0);

    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 9) < 8, pick_reg(), $urandom_range(0, 3) != 0, pick_reg(),
             $urandom_range(0, 1), $urandom_range(0, 3) != 0, pick_reg(), $urandom_range(0, 2) == 0,
             ph[0], $urandom_range(0, 99) >= 15, $urandom_range(0, 99) < 10);
      end
      idle(4, ph[0]);
    end
    do_reset();
    idle(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
